// File: rtl/alu_sequencer.sv
// alu_sequencer: collects two operand beats, holds them on an external ALU for
// EXEC_CYCLES cycles, captures the result and presents it with a valid/ready handshake.
`default_nettype none

module alu_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] din,
  input  logic       op_in,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_op,
  input  logic [7:0] alu_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] result,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic       op_reg;
  logic [7:0] result_reg;
  logic [7:0] op_count_reg;
  logic [3:0] exec_cnt;

  logic load_a;
  logic load_b;
  logic capture;
  logic complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // flush wins over every transfer, so all enables are dropped when it is high
  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            load_a    = 1'b1;
            state_nxt = GOT_A;
          end
        end
        GOT_A: begin
          if (in_valid) begin
            load_b    = 1'b1;
            state_nxt = EXEC;
          end
        end
        EXEC: begin
          if (exec_cnt == EXEC_LAST) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= 8'h00;
      b_reg        <= 8'h00;
      op_reg       <= 1'b0;
      result_reg   <= 8'h00;
      op_count_reg <= 8'h00;
      exec_cnt     <= 4'd0;
    end else begin
      if (load_a) begin
        a_reg  <= din;
        op_reg <= op_in;
      end
      if (load_b) begin
        b_reg <= din;
      end
      if (capture) begin
        result_reg <= alu_y;
      end
      if (complete) begin
        op_count_reg <= op_count_reg + 8'd1;
      end
      if (load_b || capture || flush) begin
        exec_cnt <= 4'd0;
      end else if (state == EXEC) begin
        exec_cnt <= exec_cnt + 4'd1;
      end
    end
  end

  assign in_ready  = (state == IDLE) || (state == GOT_A);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_op    = (state == EXEC) ? op_reg : 1'b0;
  assign result    = result_reg;
  assign op_count  = op_count_reg;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: two sequencers (EXEC_CYCLES 1 and 4) against a transaction-level model.
`default_nettype none

module tb_alu_sequencer;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      flush;
  logic [1:0]      in_valid;
  logic [1:0]      op_in;
  logic [1:0]      res_ready;
  logic [1:0][7:0] din;

  wire  [1:0]      in_ready;
  wire  [1:0]      alu_op;
  wire  [1:0]      res_valid;
  wire  [1:0]      busy;
  wire  [1:0][7:0] alu_a;
  wire  [1:0][7:0] alu_b;
  wire  [1:0][7:0] alu_y;
  wire  [1:0][7:0] result;
  wire  [1:0][7:0] op_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt [2];
  int lat     [2];

  always #5 clk = ~clk;

  // downstream ALU: add when alu_op is high, otherwise zero
  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign alu_y[g] = alu_op[g] ? 8'(alu_a[g] + alu_b[g]) : 8'h00;
  end

  alu_sequencer #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .din(din[0]), .op_in(op_in[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_y(alu_y[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .result(result[0]),
    .busy(busy[0]), .op_count(op_count[0])
  );

  alu_sequencer #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .din(din[1]), .op_in(op_in[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_y(alu_y[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .result(result[1]),
    .busy(busy[1]), .op_count(op_count[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int k);
    check("rst_in_ready", in_ready[k], 1);
    check("rst_res_valid", res_valid[k], 0);
    check("rst_busy", busy[k], 0);
    check("rst_alu_op", alu_op[k], 0);
    check("rst_alu_a", alu_a[k], 0);
    check("rst_alu_b", alu_b[k], 0);
    check("rst_result", result[k], 0);
    check("rst_op_count", op_count[k], 0);
  endtask

  // full operation: two beats, execute, optional backpressure, then handshake (optionally flushed)
  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic op, input int hold, input bit flush_done);
    int         n;
    logic [7:0] exp_y;
    exp_y = op ? 8'((a + b) % 256) : 8'h00;
    check("idle_in_ready", in_ready[k], 1);
    in_valid[k] = 1'b1;
    din[k]      = a;
    op_in[k]    = op;
    tick();
    check("got_a_busy", busy[k], 1);
    check("got_a_alu_op", alu_op[k], 0);
    din[k]   = b;
    op_in[k] = ~op;
    tick();
    in_valid[k] = 1'b0;
    n = 0;
    while (!res_valid[k] && n < 40) begin
      check("exec_alu_op", alu_op[k], op);
      check("exec_alu_ab", {alu_a[k], alu_b[k]}, {a, b});
      check("exec_in_ready", in_ready[k], 0);
      tick();
      n++;
    end
    check("latency", n, lat[k]);
    check("result", result[k], exp_y);
    check("done_alu_op", alu_op[k], 0);
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'b1;
      din[k]      = 8'($urandom);
      tick();
      check("bp_result", result[k], exp_y);
      check("bp_in_ready", in_ready[k], 0);
      check("bp_res_valid", res_valid[k], 1);
    end
    in_valid[k]  = 1'b0;
    res_ready[k] = 1'b1;
    flush[k]     = flush_done;
    tick();
    res_ready[k] = 1'b0;
    flush[k]     = 1'b0;
    if (!flush_done) exp_cnt[k] = (exp_cnt[k] + 1) % 256;
    check("op_count", op_count[k], exp_cnt[k]);
    check("post_busy", busy[k], 0);
    check("post_result", result[k], exp_y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lat[0] = 1;
    lat[1] = 4;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    rst_n = 1'b0;
    flush = '0; in_valid = '0; op_in = '0; res_ready = '0; din = '0;
    #1;
    check_reset(0);
    check_reset(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(0, 8'h12, 8'h34, 1'b1, 0, 1'b0);
    run_op(0, 8'hFF, 8'h02, 1'b1, 0, 1'b0);
    run_op(0, 8'h55, 8'hAA, 1'b0, 0, 1'b0);
    run_op(0, 8'h21, 8'h43, 1'b1, 10, 1'b0);
    run_op(1, 8'h80, 8'h90, 1'b1, 2, 1'b0);
    run_op(0, 8'h10, 8'h20, 1'b1, 1, 1'b1);
    run_op(1, 8'h7F, 8'h01, 1'b1, 0, 1'b1);

    // res_ready in IDLE has no effect
    res_ready[0] = 1'b1;
    tick();
    res_ready[0] = 1'b0;
    check("idle_rr_count", op_count[0], exp_cnt[0]);
    check("idle_rr_valid", res_valid[0], 0);

    // flush colliding with the second beat: beat dropped, registers hold
    in_valid[0] = 1'b1; din[0] = 8'h3C; op_in[0] = 1'b1;
    tick();
    din[0] = 8'hC3; flush[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0; flush[0] = 1'b0;
    check("flush_b_busy", busy[0], 0);
    check("flush_b_alu_a", alu_a[0], 8'h3C);
    run_op(0, 8'h05, 8'h06, 1'b1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    // asynchronous reset in the middle of EXEC on the 4-cycle instance
    in_valid[1] = 1'b1; din[1] = 8'hA5; op_in[1] = 1'b1;
    tick();
    din[1] = 8'h5A;
    tick();
    in_valid[1] = 1'b0;
    tick();
    check("mid_exec_busy", busy[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset(1);
    check_reset(0);
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    #1;
    rst_n = 1'b1;
    tick();
    run_op(1, 8'h0F, 8'hF0, 1'b1, 0, 1'b0);
    run_op(1, 8'hFE, 8'h03, 1'b1, 1, 1'b0);

    for (int i = 0; i < 256; i++) begin
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0);
    end
    check("count_wrap", op_count[0], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
